// File: rtl/rt_ibex_pcs_pkg.sv
// Shared types for the rt-ibex preemptive context-save stack.
// Default geometry, FSM state encoding and the stored context layout.
package rt_ibex_pcs_pkg;

    localparam int unsigned PcsNrSavedRegs = 9;
    localparam int unsigned PcsDataWidth   = 32;
    localparam int unsigned PcsDepth       = 8;
    localparam int unsigned PcsLevelWidth  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STORE   = 2'd1,
        POP     = 2'd2,
        RESTORE = 2'd3
    } pcs_state_e;

    typedef struct packed {
        logic [PcsLevelWidth-1:0]                      level;
        logic [PcsNrSavedRegs-1:0][PcsDataWidth-1:0]   data;
    } ctx_t;

endpackage

// File: rtl/rt_ibex_pcs_ctx_stack_if.sv
// Save/restore and control bundle between the core, the CLIC side
// and the context stack.
interface rt_ibex_pcs_ctx_stack_if #(
    parameter int unsigned NrSavedRegs   = 9,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned Depth         = 8,
    parameter int unsigned IrqLevelWidth = 8
);
    localparam int unsigned Cw = $clog2(Depth + 1);

    logic                                   irq_ack_i;
    logic [IrqLevelWidth-1:0]               irq_level_i;
    logic [NrSavedRegs-1:0][DataWidth-1:0]  store_data_i;
    logic                                   next_mret_i;
    logic                                   flush_i;
    logic [NrSavedRegs-1:0][DataWidth-1:0]  restore_data_o;
    logic [IrqLevelWidth-1:0]               restore_level_o;
    logic                                   restore_en_o;
    logic                                   busy_o;
    logic [Cw-1:0]                          count_o;
    logic                                   full_o;
    logic                                   empty_o;
    logic                                   overflow_o;
    logic                                   underflow_o;

    modport slave (
        input  irq_ack_i, irq_level_i, store_data_i, next_mret_i, flush_i,
        output restore_data_o, restore_level_o, restore_en_o, busy_o,
        output count_o, full_o, empty_o, overflow_o, underflow_o
    );

    modport master (
        output irq_ack_i, irq_level_i, store_data_i, next_mret_i, flush_i,
        input  restore_data_o, restore_level_o, restore_en_o, busy_o,
        input  count_o, full_o, empty_o, overflow_o, underflow_o
    );

endinterface

// File: rtl/rt_ibex_pcs_ctx_mem.sv
// Depth x context flip-flop array, one write port and one async read port.
// Contents are not reset; only entries below the stack count are meaningful.
module rt_ibex_pcs_ctx_mem
    import rt_ibex_pcs_pkg::*;
#(
    parameter int unsigned Depth = 8,
    parameter type         ctx_T = ctx_t,
    localparam int unsigned Aw   = $clog2(Depth)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [Aw-1:0] waddr_i,
    input  ctx_T          wdata_i,
    input  logic [Aw-1:0] raddr_i,
    output ctx_T          rdata_o
);

    ctx_T mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rt_ibex_pcs_ctx_stack.sv
// Hardware context-save stack: pushes a register context plus level on
// interrupt acknowledge, pops it back on mret.
module rt_ibex_pcs_ctx_stack
    import rt_ibex_pcs_pkg::*;
#(
    parameter int unsigned NrSavedRegs   = PcsNrSavedRegs,
    parameter int unsigned DataWidth     = PcsDataWidth,
    parameter int unsigned Depth         = PcsDepth,
    parameter int unsigned IrqLevelWidth = PcsLevelWidth
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    rt_ibex_pcs_ctx_stack_if.slave    bus
);

    localparam int unsigned Cw = $clog2(Depth + 1);
    localparam int unsigned Aw = $clog2(Depth);

    typedef logic [NrSavedRegs-1:0][DataWidth-1:0] data_t;

    typedef struct packed {
        logic [IrqLevelWidth-1:0] level;
        data_t                    data;
    } stk_ctx_t;

    pcs_state_e               state_q, state_d;
    logic [Cw-1:0]            count_q, count_d;
    logic [IrqLevelWidth-1:0] level_q, level_d;
    logic                     full_q, empty_q;
    logic                     ovf_q, ovf_d;
    logic                     udf_q, udf_d;
    data_t                    rdata_q, rdata_d;
    logic [IrqLevelWidth-1:0] rlevel_q, rlevel_d;

    logic                     we;
    logic [Cw-1:0]            cnt_m1;
    stk_ctx_t                 wctx;
    stk_ctx_t                 rctx;

    assign cnt_m1     = count_q - Cw'(1);
    assign wctx.level = level_q;
    assign wctx.data  = bus.store_data_i;

    rt_ibex_pcs_ctx_mem #(
        .Depth (Depth),
        .ctx_T (stk_ctx_t)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (count_q[Aw-1:0]),
        .wdata_i (wctx),
        .raddr_i (cnt_m1[Aw-1:0]),
        .rdata_o (rctx)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        rdata_d  = rdata_q;
        rlevel_d = rlevel_q;
        we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                // An ack wins over a same-cycle mret; that mret is lost.
                if (bus.irq_ack_i) begin
                    level_d = bus.irq_level_i;
                    state_d = STORE;
                end else if (bus.next_mret_i) begin
                    state_d = POP;
                end
            end
            STORE: begin
                if (full_q) begin
                    ovf_d = 1'b1;
                end else begin
                    we      = 1'b1;
                    count_d = count_q + Cw'(1);
                end
                state_d = IDLE;
            end
            POP: begin
                if (empty_q) begin
                    udf_d    = 1'b1;
                    rdata_d  = '0;
                    rlevel_d = '0;
                end else begin
                    rdata_d  = rctx.data;
                    rlevel_d = rctx.level;
                    count_d  = cnt_m1;
                end
                state_d = RESTORE;
            end
            RESTORE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush_i) begin
            state_d = IDLE;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
            we      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            count_q  <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            rdata_q  <= '0;
            rlevel_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            level_q  <= level_d;
            full_q   <= (count_d == Cw'(Depth));
            empty_q  <= (count_d == '0);
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            rdata_q  <= rdata_d;
            rlevel_q <= rlevel_d;
        end
    end

    assign bus.restore_data_o  = rdata_q;
    assign bus.restore_level_o = rlevel_q;
    assign bus.restore_en_o    = (state_q == RESTORE) && !bus.flush_i;
    assign bus.busy_o          = (state_q != IDLE);
    assign bus.count_o         = count_q;
    assign bus.full_o          = full_q;
    assign bus.empty_o         = empty_q;
    assign bus.overflow_o      = ovf_q;
    assign bus.underflow_o     = udf_q;

endmodule

// File: doc/rt_ibex_pcs_ctx_stack.md
Name: rt_ibex_pcs_ctx_stack

Overview:
Parametrised hardware context-save stack for the rt-ibex preemptive interrupt path. It pushes NrSavedRegs register words plus the interrupt level on interrupt acknowledge, and pops them on mret. It is built from flip-flops with a pointer-indexed array, so no entries are shifted on each operation. It adds occupancy tracking, full/empty flags, sticky overflow/underflow errors, a level tag per entry, and a flush. It sits between the ibex register-file save/restore port and the CLIC-side interrupt controller.

Parameters:
NrSavedRegs, 9, number of DataWidth words saved per context
DataWidth, 32, width of one saved register
Depth, 8, number of nested contexts storable (>=2)
IrqLevelWidth, 8, width of the interrupt level tag stored with each context

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
irq_ack_i  in  1  interrupt taken; request push
irq_level_i  in  IrqLevelWidth  level of the interrupt being taken, sampled with irq_ack_i
store_data_i  in  NrSavedRegs x DataWidth  context to save; must be stable in the STORE cycle
next_mret_i  in  1  mret decoded; request pop
flush_i  in  1  synchronous clear of all contexts (e.g. debug/reset-vector entry)
restore_data_o  out  NrSavedRegs x DataWidth  popped context
restore_level_o  out  IrqLevelWidth  level tag of popped context
restore_en_o  out  1  one-cycle strobe: restore_data_o/restore_level_o valid
busy_o  out  1  FSM not in IDLE; new requests ignored
count_o  out  $clog2(Depth+1)  number of stored contexts
full_o  out  1  count_o == Depth
empty_o  out  1  count_o == 0
overflow_o  out  1  sticky: push attempted while full
underflow_o  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, rst_ni=0): state IDLE, count 0, all outputs 0 except empty_o=1. Array contents need not be reset.
- FSM states: IDLE, STORE, POP, RESTORE.
- IDLE, irq_ack_i=1: latch irq_level_i; go to STORE. irq_ack_i has priority over a same-cycle next_mret_i; that mret is dropped.
- IDLE, next_mret_i=1 (no ack): go to POP.
- STORE, one cycle:
  - if not full: write store_data_i and the latched level to entry[count]; count+1.
  - if full: no write, count unchanged, set overflow_o.
  - go to IDLE.
- POP, one cycle:
  - if not empty: register entry[count-1] into the output registers; count-1.
  - if empty: set underflow_o; output registers load 0.
  - go to RESTORE.
- RESTORE, one cycle: restore_en_o=1; go to IDLE.
- Restore latency: restore_en_o is asserted exactly 2 cycles after next_mret_i is sampled in IDLE.
- restore_data_o and restore_level_o hold their value until the next POP.
- busy_o=1 in STORE, POP and RESTORE. irq_ack_i and next_mret_i arriving while busy are ignored; the core must not issue them.
- flush_i, synchronous, highest priority:
  - next cycle: count 0, state IDLE, restore_en_o 0, overflow_o and underflow_o cleared.
  - a flush in RESTORE suppresses that cycle's strobe, i.e. restore_en_o is forced 0.
- full_o, empty_o and count_o are registered and reflect the count after the operation completes.
- Overflow and underflow never corrupt stored entries.
- Entries are written only in STORE.

Decomposition:
- Package rt_ibex_pcs_pkg: pcs_state_e enum (logic [1:0]) and a ctx_t packed struct {level, data}.
- Natural sub-module: rt_ibex_pcs_ctx_mem, the Depth x ctx_t flip-flop array with one write port (we, waddr, wdata) and one combinational read port (raddr). It can later be swapped for a latch or SRAM implementation.

Test Plan:
- Push 3 contexts (data words 0x1000+i, levels 3,5,7), then 3 mrets -> restore_en_o at +2 cycles each. Levels pop 7,5,3 with matching data. count_o goes 3->0, empty_o=1.
- Push Depth+1 times -> full_o=1 after push 8. Ninth push sets overflow_o, count_o stays 8. Subsequent 8 pops return the original 8 contexts intact.
- next_mret_i with empty stack -> underflow_o=1, restore_en_o still strobes with data 0 and level 0, count_o stays 0.
- irq_ack_i and next_mret_i in the same IDLE cycle -> push only: count_o+1, no restore_en_o.
- flush_i asserted in POP with count 4 -> next cycle count_o=0, state IDLE, no restore_en_o, sticky flags cleared.
- rst_ni dropped mid-STORE -> all outputs return to reset values asynchronously. A subsequent push/pop works from count 0.
